// File: rtl/ub_read_sequencer_if.sv
// Purpose: command and port-0 read bundle between a burst requester and ub_read_sequencer.
// Latency: none, this is only a grouping of wires.
// Backpressure: cmd_valid/cmd_ready handshake; read rows are flagged by data_valid/data_last.
// Signals:
//   cmd_valid, cmd_addr, cmd_length  requester -> sequencer burst command
//   cmd_ready                        sequencer -> requester, high while a command can be taken
//   ub_en0, ub_addr0                 sequencer -> buffer port 0 read strobe and row address
//   data_valid, data_last            sequencer -> consumer, qualify the buffer's read_port0
interface ub_read_sequencer_if #(
    parameter int ADDR_WIDTH   = 12,
    parameter int LENGTH_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LENGTH_WIDTH-1:0] cmd_length;
    logic                    ub_en0;
    logic [ADDR_WIDTH-1:0]   ub_addr0;
    logic                    data_valid;
    logic                    data_last;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_length,
        output cmd_ready, ub_en0, ub_addr0, data_valid, data_last
    );

    // Requester / consumer side.
    modport master (
        output cmd_valid, cmd_addr, cmd_length,
        input  cmd_ready, ub_en0, ub_addr0, data_valid, data_last
    );
endinterface

// File: rtl/ub_read_sequencer.sv
// Purpose: issues one unified-buffer port-0 row read per cycle for a (start row, count) burst.
// Latency: first read the cycle after command acceptance; row data valid 3 enabled cycles after issue.
// Backpressure: global enable=0 freezes issue and the valid pipeline; a host master grant steals an issue slot.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              global advance shared with the buffer
//   bus (slave)         command handshake, port-0 en/addr, data_valid/data_last row flags
//   master_req/gnt      host master-port arbitration (host has priority over issue)
//   busy, done          not idle / one-cycle burst completion pulse
module ub_read_sequencer #(
    parameter int TILE_WIDTH   = 4096,
    parameter int LENGTH_WIDTH = 32,
    parameter int READ_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    ub_read_sequencer_if.slave   bus,
    input  logic                 master_req,
    output logic                 master_gnt,
    output logic                 busy,
    output logic                 done
);
    localparam int                    ADDR_WIDTH = $clog2(TILE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(TILE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    // Bit 0 tracks the buffer's RAM register, the top bit its final output register.
    logic [READ_LATENCY-1:0] v_q, v_d;
    logic [READ_LATENCY-1:0] l_q, l_d;
    logic                    done_q, done_d;

    logic issue;
    logic rem_is_one;
    logic accept;

    // A master access rewrites the buffer's RAM register. Refuse it only when a
    // burst row sits there and the output registers will not capture it this edge.
    assign master_gnt = master_req && (!v_q[0] || enable);
    assign issue      = (state_q == S_ISSUE) && enable && !master_gnt;
    assign rem_is_one = (remaining_q == LENGTH_WIDTH'(1));
    assign accept     = (state_q == S_IDLE) && bus.cmd_valid && enable;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        v_d         = v_q;
        l_d         = l_q;

        // The valid/last shadow pipeline moves in lockstep with the buffer's registers.
        if (enable) begin
            v_d = {v_q[READ_LATENCY-2:0], issue};
            l_d = {l_q[READ_LATENCY-2:0], issue && rem_is_one};
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = bus.cmd_length;
                    state_d     = (bus.cmd_length == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    cur_addr_d  = (cur_addr_q == ADDR_MAX) ? '0 : cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LENGTH_WIDTH'(1);
                    if (rem_is_one) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (v_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered pulse: high exactly in the DRAIN cycle that sees an empty pipeline,
        // which is also the cycle the FSM leaves for IDLE.
        done_d = (state_d == S_DRAIN) && (v_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            v_q         <= '0;
            l_q         <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            v_q         <= v_d;
            l_q         <= l_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.ub_en0     = issue;
    assign bus.ub_addr0   = cur_addr_q;
    assign bus.data_valid = v_q[READ_LATENCY-1];
    assign bus.data_last  = l_q[READ_LATENCY-1];
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
endmodule

// File: tb/tb_ub_read_sequencer.sv
// Purpose: directed self-checking bench for ub_read_sequencer with a small port-0 buffer model.
// Latency: cycle maps of en/valid/last/done/busy/grant compared against hand-derived constants.
// Backpressure: enable stalls and master requests driven from per-cycle masks.
module tb_ub_read_sequencer;
    localparam logic [15:0] MASTER_TAG = 16'hBEEF;
    localparam int          NCYC       = 24;

    logic clk;
    logic rst;
    logic enable;
    logic master_req;
    logic master_gnt;
    logic busy;
    logic done;

    ub_read_sequencer_if #(.ADDR_WIDTH(12), .LENGTH_WIDTH(32)) bus ();

    ub_read_sequencer #(
        .TILE_WIDTH  (4096),
        .LENGTH_WIDTH(32),
        .READ_LATENCY(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bus       (bus),
        .master_req(master_req),
        .master_gnt(master_gnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer port-0 model: RAM register is rewritten by any access (host or port 0),
    // the two output registers only advance on enable. Rows read back as their address.
    logic [15:0] r0, r1, r2;
    always @(posedge clk) begin
        if (master_gnt)
            r0 <= MASTER_TAG;
        else if (bus.ub_en0)
            r0 <= {4'h0, bus.ub_addr0};
        if (enable) begin
            r1 <= r0;
            r2 <= r1;
        end
    end

    typedef struct packed {
        logic [15:0] row;
        logic        last;
    } drow_t;

    logic [11:0] iq[$];
    drow_t       dq[$];

    task automatic push_burst(input logic [11:0] a, input int len);
        drow_t d;
        logic [11:0] addr;
        for (int i = 0; i < len; i++) begin
            addr = 12'((int'(a) + i) % 4096);
            iq.push_back(addr);
            d.row  = {4'h0, addr};
            d.last = (i == len - 1);
            dq.push_back(d);
        end
    endtask

    // Order/content monitors: every issue and every captured row must match the next expected one.
    always @(negedge clk) begin
        drow_t d;
        if (bus.ub_en0) begin
            check_val("issue_expected", 64'(iq.size() > 0), 64'd1);
            if (iq.size() > 0)
                check_val("issue_addr", 64'(bus.ub_addr0), 64'(iq.pop_front()));
        end
        if (bus.data_valid && enable) begin
            check_val("row_expected", 64'(dq.size() > 0), 64'd1);
            if (dq.size() > 0) begin
                d = dq.pop_front();
                check_val("row_data", 64'(r2), 64'(d.row));
                check_val("row_last", 64'(bus.data_last), 64'(d.last));
            end
        end
    end

    logic [NCYC-1:0] en_map, dv_map, last_map, done_map, busy_map, gnt_map;
    logic [11:0]     addr_at [0:NCYC-1];

    // Cycle 0 offers the command; its acceptance edge ends cycle 0.
    task automatic run_case(input logic [11:0] a, input logic [31:0] len,
                            input logic [NCYC-1:0] en_low, input logic [NCYC-1:0] mreq,
                            input logic [NCYC-1:0] cv, input logic [NCYC-1:0] rst_m,
                            input logic [11:0] cv_a, input logic [31:0] cv_l);
        en_map = '0; dv_map = '0; last_map = '0; done_map = '0; busy_map = '0; gnt_map = '0;
        for (int c = 0; c < NCYC; c++) begin
            rst            = rst_m[c];
            enable         = !en_low[c];
            master_req     = mreq[c];
            bus.cmd_valid  = (c == 0) || cv[c];
            bus.cmd_addr   = (c == 0) ? a : cv_a;
            bus.cmd_length = (c == 0) ? len : cv_l;
            #1;
            en_map[c]   = bus.ub_en0;
            dv_map[c]   = bus.data_valid;
            last_map[c] = bus.data_last;
            done_map[c] = done;
            busy_map[c] = busy;
            gnt_map[c]  = master_gnt;
            addr_at[c]  = bus.ub_addr0;
            @(posedge clk);
            #1;
        end
        rst = 1'b0; enable = 1'b1; master_req = 1'b0; bus.cmd_valid = 1'b0;
    endtask

    task automatic check_maps(input string n, input logic [NCYC-1:0] en, input logic [NCYC-1:0] dv,
                              input logic [NCYC-1:0] last, input logic [NCYC-1:0] dn,
                              input logic [NCYC-1:0] bz, input logic [NCYC-1:0] gn);
        check_val({n, "_en0"},  64'(en_map),   64'(en));
        check_val({n, "_dv"},   64'(dv_map),   64'(dv));
        check_val({n, "_last"}, 64'(last_map), 64'(last));
        check_val({n, "_done"}, 64'(done_map), 64'(dn));
        check_val({n, "_busy"}, 64'(busy_map), 64'(bz));
        check_val({n, "_gnt"},  64'(gnt_map),  64'(gn));
        check_val({n, "_iq_drained"}, 64'(iq.size()), 64'd0);
        check_val({n, "_dq_drained"}, 64'(dq.size()), 64'd0);
        iq.delete();
        dq.delete();
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        master_req     = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_length = '0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        enable     = 1'b0;
        master_req = 1'b1;
        #1;
        check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check_val("rst_busy",      64'(busy),           64'd0);
        check_val("rst_ub_en0",    64'(bus.ub_en0),     64'd0);
        check_val("rst_ub_addr0",  64'(bus.ub_addr0),   64'd0);
        check_val("rst_dvalid",    64'(bus.data_valid), 64'd0);
        check_val("rst_dlast",     64'(bus.data_last),  64'd0);
        check_val("rst_done",      64'(done),           64'd0);
        check_val("rst_gnt_req1",  64'(master_gnt),     64'd1);
        master_req = 1'b0;
        #1;
        check_val("rst_gnt_req0",  64'(master_gnt),     64'd0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4-row burst; a command offered in cycles 2-3 must be ignored.
        push_burst(12'd0, 4);
        run_case(12'd0, 32'd4, '0, '0, 24'h00000C, '0, 12'd100, 32'd7);
        check_maps("basic", 24'h00001E, 24'h0000F0, 24'h000080, 24'h000100, 24'h0001FE, 24'h0);
        check_val("basic_addr1", 64'(addr_at[1]), 64'd0);
        check_val("basic_addr4", 64'(addr_at[4]), 64'd3);

        // Two enable-low cycles right after the second issue.
        push_burst(12'd10, 4);
        run_case(12'd10, 32'd4, 24'h000018, '0, '0, '0, 12'd0, 32'd0);
        check_maps("stall", 24'h000066, 24'h0003C0, 24'h000200, 24'h000400, 24'h0007FE, 24'h0);

        // Host holds the master port for cycles 2-4 with enable high.
        push_burst(12'd20, 4);
        run_case(12'd20, 32'd4, '0, 24'h00001C, '0, '0, 12'd0, 32'd0);
        check_maps("master", 24'h0000E2, 24'h000710, 24'h000400, 24'h000800, 24'h000FFE, 24'h00001C);

        // Request while stalled with a row in the RAM register: grant withheld.
        push_burst(12'd30, 4);
        run_case(12'd30, 32'd4, 24'h000004, 24'h000004, '0, '0, 12'd0, 32'd0);
        check_maps("withhold", 24'h00003A, 24'h0001E0, 24'h000100, 24'h000200, 24'h0003FE, 24'h0);

        // Wrap at the last row of the tile.
        push_burst(12'd4094, 4);
        run_case(12'd4094, 32'd4, '0, '0, '0, '0, 12'd0, 32'd0);
        check_maps("wrap", 24'h00001E, 24'h0000F0, 24'h000080, 24'h000100, 24'h0001FE, 24'h0);
        check_val("wrap_addr1", 64'(addr_at[1]), 64'd4094);
        check_val("wrap_addr2", 64'(addr_at[2]), 64'd4095);
        check_val("wrap_addr3", 64'(addr_at[3]), 64'd0);
        check_val("wrap_addr4", 64'(addr_at[4]), 64'd1);

        // Zero-length command, offer in cycle 1 ignored, 1-row command taken in cycle 2.
        push_burst(12'd60, 1);
        run_case(12'd50, 32'd0, '0, '0, 24'h000006, '0, 12'd60, 32'd1);
        check_maps("zero_b2b", 24'h000008, 24'h000040, 24'h000040, 24'h000082, 24'h0000FA, 24'h0);

        // Reset during ISSUE: two rows issued, none flagged, no done.
        iq.push_back(12'd70);
        iq.push_back(12'd71);
        run_case(12'd70, 32'd4, '0, '0, '0, 24'h000004, 12'd0, 32'd0);
        check_maps("rst_mid", 24'h000006, 24'h0, 24'h0, 24'h0, 24'h000006, 24'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ub_read_sequencer.md
# ub_read_sequencer

Read-side controller for port 0 of the unified buffer. It accepts a burst command (start row, row count) and issues one row read per cycle on port 0. It tracks the buffer's 3-stage read latency under the global `enable` stall and flags each row as it appears on `read_port0`. It also arbitrates port 0 against host master accesses, which override port 0 inside the buffer, so in-flight rows are never corrupted.

## Interface
Parameters:
- `TILE_WIDTH`, 4096: buffer depth in rows; the row address wraps at this value.
- `LENGTH_WIDTH`, 32: width of the row-count field.
- `READ_LATENCY`, 3: cycles from issue to valid data on `read_port0` (RAM register plus two output registers). Fixed; only 3 is supported.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: global advance; the same signal that drives the buffer's `enable`.
- `cmd_valid`, in, 1: burst command offered.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_addr`, in, `buffer_addr_type`: first row of the burst.
- `cmd_length`, in, `LENGTH_WIDTH`: number of rows; 0 is legal.
- `master_req`, in, 1: host wants the buffer master port this cycle.
- `master_gnt`, out, 1: host may drive `master_en` this cycle.
- `ub_en0`, out, 1: drives the buffer's `en0`.
- `ub_addr0`, out, `buffer_addr_type`: drives the buffer's `addr0`.
- `data_valid`, out, 1: `read_port0` holds a burst row this cycle.
- `data_last`, out, 1: qualifies `data_valid`; marks the final row of the burst.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse at burst completion.

## Operation
- States are IDLE, ISSUE and DRAIN. `cmd_ready` = (state == IDLE). `busy` = !IDLE.
- **IDLE:** on `cmd_valid && enable`, latch `cur_addr` = `cmd_addr` and `remaining` = `cmd_length`.
  - If `cmd_length` == 0: go to DRAIN with an empty pipeline.
  - Otherwise: go to ISSUE.
- **ISSUE:**
  - Issue condition: `issue` = ISSUE && `enable` && !`master_gnt`.
  - `ub_en0` = `issue`. `ub_addr0` = `cur_addr`.
  - On `issue`: `cur_addr` advances, with `TILE_WIDTH-1` → 0. `remaining` decrements.
  - When `remaining` == 1 on an issue, go to DRAIN.
- **Valid pipeline:** valid bits v0, v1, v2 plus matching last bits l0, l1, l2.
  - The pipeline shifts only when `enable`=1: v0 <= `issue`, l0 <= `issue` && `remaining`==1, v1 <= v0, v2 <= v1, and likewise for the last bits.
  - `data_valid` = v2. `data_last` = l2.
- **DRAIN:** when v0, v1 and v2 are all clear, assert `done` for exactly one cycle (registered) and go to IDLE.
- **Arbitration:** `master_gnt` = `master_req` && (!v0 || `enable`).
  - The master has priority over issue.
  - The grant is withheld only while a row sits in the buffer's RAM output register and the output registers are stalled. A master access at that point would overwrite the row before it is captured.
  - `master_gnt` is independent of state; it is also granted in IDLE.
- **Width rules:** `remaining` is `LENGTH_WIDTH` bits and never underflows; issue stops at 1 → DRAIN. The address is compared against `TILE_WIDTH-1` for wrap, not against the type width.
- **Stall:** `enable`=0 freezes issue, the valid pipeline and the state transitions out of IDLE. DRAIN completion still requires the pipeline to drain, which needs `enable` cycles.

## Timing
- **Reset:** on the `rst` edge, state = IDLE, `cur_addr` = 0, `remaining` = 0, all v/l bits cleared, `done` = 0.
- **Output values in the cycle after reset:** `cmd_ready`=1, `busy`=0, `ub_en0`=0, `ub_addr0`=0, `data_valid`=0, `data_last`=0, `done`=0. `master_gnt` = `master_req`.
- **Reset mid-burst:** the burst is abandoned with no `done`. Rows already in the buffer pipeline appear on `read_port0` but are not flagged.
- **Command to first issue:** command accepted at edge k; first `ub_en0` in cycle k+1.
- **Issue to data:** issue in cycle t with `enable` held high gives `data_valid` in cycle t+3.
- **Throughput:** one row per cycle. An N-row burst with no stalls has its last row valid at cycle k+N+3, `done` high in cycle k+N+4 and `cmd_ready` in cycle k+N+5.
- **Stall effect:** each `enable`=0 cycle or master grant adds exactly one cycle, with no gaps or duplicates in the row sequence.
- **Zero-length command:** `done` is high in the cycle after acceptance; `ub_en0` and `data_valid` stay low.
- **Command while busy:** ignored (`cmd_ready`=0).

## Test plan
- **Basic burst:** reset, then `cmd_addr`=0, `cmd_length`=4, `enable`=1. Expect `ub_en0` in cycles 1–4 with addresses 0..3; `data_valid` in cycles 4–7 showing rows 0x7273…7F, 0x6465…71, 0x5657…63, 0x4849…55; `data_last` in cycle 7; `done` in cycle 8.
- **Enable stall:** same burst with `enable`=0 for 2 cycles after the second issue. Rows arrive in order with no duplicates; `done` moves 2 cycles later.
- **Master contention:** `master_req` high for 3 cycles mid-burst. `master_gnt`=1 for those cycles and no issue occurs in them. With `enable`=0 and v0=1, `master_gnt`=0. Data remains correct.
- **Address wrap:** `cmd_addr`=4094, `cmd_length`=4 → addresses 4094, 4095, 0, 1; the rows for 0 and 1 match the reset contents.
- **Zero length and back-to-back:** `cmd_length`=0 gives a `done` pulse with no `ub_en0`; a new command is accepted 2 cycles later. `cmd_valid` offered during a burst is ignored.
- **Reset mid-burst:** `rst` during ISSUE gives IDLE next cycle, `data_valid` stays 0 and `done` never fires.
